// File: rtl/act_buffer.sv
// act_buffer: single-clock activation buffer. Words are written through a
// simple write port and streamed out as bursts through a valid/ready port.
// Read path: fetch address -> synchronous RAM read -> 2-entry output buffer,
// giving a first word two edges after rd_start is accepted.
// Optional feature macro: ACT_BUFFER_CLEAR_EN enables a post-reset sweep that
// zero-fills the storage (clr_busy high while it runs).
module act_buffer #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_start,
  input  logic [ADDR_WIDTH-1:0] rd_base,
  input  logic [ADDR_WIDTH:0]   rd_len,
  output logic                  rd_busy,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last,
  output logic                  clr_busy
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t                  state;
  logic [ADDR_WIDTH-1:0]   fetch_addr;
  logic [ADDR_WIDTH:0]     fetch_left;
  logic                    fetch;
  logic                    pop;
  logic [1:0]              occ;
  logic                    rd_vld;
  logic                    rd_last;
  logic [DATA_WIDTH-1:0]   rd_data;

  // Second output-buffer slot; the head slot is out_valid/out_data/out_last.
  logic                    b1_valid;
  logic                    b1_last;
  logic [DATA_WIDTH-1:0]   b1_data;

  logic                    hv_n, hl_n, bv_n, bl_n;
  logic [DATA_WIDTH-1:0]   hd_n, bd_n;

  logic                    mem_we;
  logic [ADDR_WIDTH-1:0]   mem_waddr;
  logic [DATA_WIDTH-1:0]   mem_wdata;

`ifdef ACT_BUFFER_CLEAR_EN
  logic [DATA_WIDTH-1:0]   mem [DEPTH];
  logic [ADDR_WIDTH-1:0]   clr_addr;
  logic                    clr_q;

  // Zero-fill sweep: one address per cycle after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clr_q    <= 1'b1;
      clr_addr <= '0;
    end else if (clr_q) begin
      clr_addr <= clr_addr + ADDR_WIDTH'(1);
      if (clr_addr == '1) clr_q <= 1'b0;
    end
  end

  assign clr_busy = clr_q;

  // The sweep owns the write port until it finishes; user writes are dropped.
  always_comb begin
    mem_we    = clr_q | wr_en;
    mem_waddr = clr_q ? clr_addr : wr_addr;
    mem_wdata = clr_q ? '0 : wr_data;
  end
`else
  logic [DATA_WIDTH-1:0]   mem [DEPTH] = '{default: '0};

  assign clr_busy = 1'b0;

  // Write port driven straight from the user interface.
  always_comb begin
    mem_we    = wr_en;
    mem_waddr = wr_addr;
    mem_wdata = wr_data;
  end
`endif

  // Credit check: head + slot 1 + in-flight read never exceed two words.
  always_comb begin
    pop   = out_valid & out_ready;
    occ   = {1'b0, out_valid} + {1'b0, b1_valid} + {1'b0, rd_vld};
    fetch = (state == RUN) && (fetch_left != '0) && ((occ < 2'd2) || pop);
  end

  // Storage: write port plus synchronous read; same-address read sees old data.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
    if (fetch)  rd_data <= mem[fetch_addr];
  end

  // Output buffer next state: the head refills from slot 1 first, then from
  // the arriving read word, so ordering is preserved across stalls.
  always_comb begin
    hv_n = out_valid;
    hd_n = out_data;
    hl_n = out_last;
    bv_n = b1_valid;
    bd_n = b1_data;
    bl_n = b1_last;
    if (pop) begin
      if (b1_valid) begin
        hv_n = 1'b1;
        hd_n = b1_data;
        hl_n = b1_last;
        bv_n = rd_vld;
        bd_n = rd_vld ? rd_data : '0;
        bl_n = rd_vld & rd_last;
      end else if (rd_vld) begin
        hv_n = 1'b1;
        hd_n = rd_data;
        hl_n = rd_last;
      end else begin
        hv_n = 1'b0;
        hd_n = '0;
        hl_n = 1'b0;
      end
    end else if (rd_vld) begin
      if (out_valid) begin
        bv_n = 1'b1;
        bd_n = rd_data;
        bl_n = rd_last;
      end else begin
        hv_n = 1'b1;
        hd_n = rd_data;
        hl_n = rd_last;
      end
    end
  end

  // Read FSM, fetch pointer and output buffer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      rd_busy    <= 1'b0;
      fetch_addr <= '0;
      fetch_left <= '0;
      rd_vld     <= 1'b0;
      rd_last    <= 1'b0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_last   <= 1'b0;
      b1_valid   <= 1'b0;
      b1_data    <= '0;
      b1_last    <= 1'b0;
    end else begin
      rd_vld    <= fetch;
      out_valid <= hv_n;
      out_data  <= hd_n;
      out_last  <= hl_n;
      b1_valid  <= bv_n;
      b1_data   <= bd_n;
      b1_last   <= bl_n;
      if (fetch) begin
        rd_last    <= (fetch_left == (ADDR_WIDTH + 1)'(1));
        fetch_addr <= fetch_addr + ADDR_WIDTH'(1);
        fetch_left <= fetch_left - (ADDR_WIDTH + 1)'(1);
      end
      case (state)
        IDLE: begin
          if (rd_start && (rd_len != '0) && !clr_busy) begin
            state      <= RUN;
            rd_busy    <= 1'b1;
            fetch_addr <= rd_base;
            fetch_left <= rd_len;
          end
        end
        RUN: begin
          if (pop && out_last) begin
            state   <= IDLE;
            rd_busy <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_act_buffer.sv
// tb_act_buffer: directed scenarios plus randomized traffic, checked every
// cycle against a burst-level reference model (memory array + expected word
// list + latency countdown). Works with or without ACT_BUFFER_CLEAR_EN.
module tb_act_buffer;

  localparam int AW    = 4;
  localparam int DW    = 8;
  localparam int DEPTH = 16;
`ifdef ACT_BUFFER_CLEAR_EN
  localparam int CLR = 1;
`else
  localparam int CLR = 0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          rd_start;
  logic [AW-1:0] rd_base;
  logic [AW:0]   rd_len;
  logic          rd_busy;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          out_last;
  logic          clr_busy;

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic [DW-1:0] m_mem [DEPTH] = '{default: '0};
  logic [DW-1:0] m_q_data [DEPTH];
  bit            m_busy;
  int            m_delay, m_head, m_len, m_clr;
  int            cur_base, cur_len;

  logic [DW-1:0] got_d[$];
  logic          got_l[$];
  logic [15:0]   pat = 16'hD1A9;

  always #5 clk = ~clk;

  act_buffer #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_start(rd_start), .rd_base(rd_base), .rd_len(rd_len),
    .rd_busy(rd_busy), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_last(out_last), .clr_busy(clr_busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: compare at negedge, then apply the rules of the coming edge.
  initial begin : model
    bit            exp_v, exp_l, busy_now;
    logic [DW-1:0] exp_d;
    m_busy = 0; m_delay = 0; m_head = 0; m_len = 0; m_clr = 0;
    cur_base = 0; cur_len = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        m_busy = 0; m_delay = 0; m_head = 0; m_len = 0;
        m_clr = (CLR != 0) ? DEPTH : 0;
      end
      exp_v = m_busy && (m_delay == 0);
      exp_d = exp_v ? m_q_data[m_head] : '0;
      exp_l = exp_v && (m_head == m_len - 1);
      check("m_out_valid", 32'(out_valid), 32'(exp_v));
      check("m_out_data",  32'(out_data),  32'(exp_d));
      check("m_out_last",  32'(out_last),  32'(exp_l));
      check("m_rd_busy",   32'(rd_busy),   32'(m_busy));
      check("m_clr_busy",  32'(clr_busy),  32'(m_clr != 0));
      if (rst_n) begin
        busy_now = m_busy;
        if (exp_v && out_ready) begin
          if (exp_l) m_busy = 0;
          else m_head++;
        end
        if (busy_now && m_delay > 0) m_delay--;
        if (!busy_now && rd_start && rd_len != 0 && m_clr == 0) begin
          m_busy = 1; m_delay = 2; m_head = 0; m_len = int'(rd_len);
          for (int k = 0; k < m_len; k++)
            m_q_data[k] = m_mem[(int'(rd_base) + k) % DEPTH];
          cur_base = int'(rd_base); cur_len = int'(rd_len);
        end
        if (m_clr != 0) begin
          m_mem[DEPTH - m_clr] = '0;
          m_clr--;
        end else if (wr_en) begin
          m_mem[wr_addr] = wr_data;
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write(input int a, input int d);
    wr_en = 1'b1; wr_addr = AW'(a); wr_data = DW'(d);
    tick();
    wr_en = 1'b0;
  endtask

  task automatic start(input int b, input int l);
    rd_start = 1'b1; rd_base = AW'(b); rd_len = (AW + 1)'(l);
    tick();
    rd_start = 1'b0;
  endtask

  task automatic release_reset();
    int n = 0;
    rst_n = 1'b1;
    while (clr_busy && n < 100) begin
      tick();
      n++;
    end
    check("clr_cycles", 32'(n), 32'((CLR != 0) ? DEPTH : 0));
  endtask

  task automatic drain(input int max_cycles, input bit toggle);
    got_d.delete();
    got_l.delete();
    for (int c = 0; c < max_cycles; c++) begin
      out_ready = toggle ? pat[c % 16] : 1'b1;
      @(negedge clk);
      if (out_valid && out_ready) begin
        got_d.push_back(out_data);
        got_l.push_back(out_last);
      end
      tick();
      if (!rd_busy) break;
    end
    check("drain_done", 32'(rd_busy), 32'(0));
    out_ready = 1'b1;
  endtask

  task automatic check_seq(input string name, input int n, input int v0, input int dv);
    check({name, "_count"}, 32'(got_d.size()), 32'(n));
    for (int k = 0; k < n && k < got_d.size(); k++) begin
      check({name, "_data"}, 32'(got_d[k]), 32'((v0 + dv * k) & 8'hFF));
      check({name, "_last"}, 32'(got_l[k]), 32'(k == n - 1));
    end
  endtask

  function automatic bit outside_burst(input int a);
    return ((a - cur_base + DEPTH) % DEPTH) >= cur_len;
  endfunction

  initial begin : stim
    int hs;
    int a;
    int r;
    rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    rd_start = 1'b0; rd_base = '0; rd_len = '0; out_ready = 1'b1;
    repeat (3) tick();
    check("rst_out_valid", 32'(out_valid), 32'(0));
    check("rst_rd_busy",   32'(rd_busy),   32'(0));
    check("rst_out_data",  32'(out_data),  32'(0));
    check("rst_clr_busy",  32'(clr_busy),  32'(CLR));
    release_reset();

    // Preload, reset, attempt a write during the sweep, read everything back
    for (int i = 0; i < DEPTH; i++) write(i, 'h50 + i);
    rst_n = 1'b0;
    tick(); tick();
    wr_en = 1'b1; wr_addr = AW'(5); wr_data = 8'h77;
    release_reset();
    wr_en = 1'b0;
    start(0, 16);
    drain(60, 1'b0);
    check_seq("sweep", 16, (CLR != 0) ? 0 : 'h50, (CLR != 0) ? 0 : 1);

    // Basic burst with exact cycle timing
    for (int i = 0; i < 4; i++) write(i, i + 1);
    start(0, 4);
    @(negedge clk);
    check("t0_busy",  32'(rd_busy),   32'(1));
    check("t0_valid", 32'(out_valid), 32'(0));
    @(negedge clk);
    check("t1_valid", 32'(out_valid), 32'(0));
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("t_valid", 32'(out_valid), 32'(1));
      check("t_data",  32'(out_data),  32'(k + 1));
      check("t_last",  32'(out_last),  32'(k == 3));
    end
    @(negedge clk);
    check("t_end_busy",  32'(rd_busy),   32'(0));
    check("t_end_valid", 32'(out_valid), 32'(0));
    tick();

    // Ignored starts: in RUN with another base, and len=0 in IDLE
    out_ready = 1'b0;
    start(0, 4);
    start(8, 3);
    @(negedge clk);
    check("ign_busy", 32'(rd_busy), 32'(1));
    tick();
    drain(40, 1'b0);
    check_seq("ign", 4, 1, 1);
    start(0, 0);
    @(negedge clk);
    check("len0_busy",  32'(rd_busy),   32'(0));
    check("len0_valid", 32'(out_valid), 32'(0));
    tick();

    // Wrap past the top address
    write(15, 'hAA);
    write(0, 'hBB);
    start(15, 2);
    drain(20, 1'b0);
    check_seq("wrap", 2, 'hAA, 'h11);

    // Backpressure with a toggling ready
    for (int i = 0; i < 8; i++) write(3 + i, 'h30 + i);
    start(3, 8);
    drain(80, 1'b1);
    check_seq("stall", 8, 'h30, 1);

    // Reset in the middle of a burst
    for (int i = 0; i < 6; i++) write(i, 'h60 + i);
    start(0, 6);
    hs = 0;
    for (int c = 0; c < 20 && hs < 2; c++) begin
      @(negedge clk);
      if (out_valid && out_ready) hs++;
      tick();
    end
    check("mid_hs", 32'(hs), 32'(2));
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(out_valid), 32'(0));
    check("mid_rst_busy",  32'(rd_busy),   32'(0));
    check("mid_rst_data",  32'(out_data),  32'(0));
    tick(); tick();
    release_reset();
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("post_rst_valid", 32'(out_valid), 32'(0));
    end
    tick();
    start(0, 1);
    drain(20, 1'b0);
    check_seq("post_rst", 1, (CLR != 0) ? 0 : 'h60, 0);

    // Randomized traffic against the model
    for (int it = 0; it < 400; it++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      rd_start = 1'b0;
      wr_en = 1'b0;
      r = int'($urandom_range(0, 99));
      if (r < 2) begin
        rst_n = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
      end else begin
        if (r < 22) begin
          rd_start = 1'b1;
          rd_base = AW'($urandom_range(0, DEPTH - 1));
          rd_len = (AW + 1)'($urandom_range(0, DEPTH));
        end else if (r < 70) begin
          a = int'($urandom_range(0, DEPTH - 1));
          if (!m_busy || outside_burst(a)) begin
            wr_en = 1'b1;
            wr_addr = AW'(a);
            wr_data = DW'($urandom);
          end
        end
        tick();
      end
    end
    rd_start = 1'b0;
    wr_en = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 100 && (rd_busy || clr_busy); c++) tick();
    check("final_idle", 32'(rd_busy), 32'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
